// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader
// Observes a multiplexed, active-low 7-segment display bus and recovers the
// BCD value shown on each digit. A digit is captured only after its
// {segments, enables} pattern has been seen unchanged for STABLE_CYC samples.
// Captured values stay in per-digit registers. A frame pulse marks the point
// where every digit has been refreshed. An error pulse flags undecodable
// patterns.

module seg7_scan_reader #(
   parameter int DIGITS     = 4,
   parameter int STABLE_CYC = 4,
   parameter int AN_ACT_LOW = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [6:0]            seg_in,
   input  logic [DIGITS-1:0]     an_in,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic [DIGITS-1:0]     digit_valid,
   output logic                  frame_valid,
   output logic                  err,
   output logic [2:0]            err_digit
);

   localparam int CNT_W = $clog2(STABLE_CYC + 1);
   localparam int SMP_W = 7 + DIGITS;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_HOLD   = 2'd2;

   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   // Count value at which the next matching sample completes the stable run
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);

   // Returns {unknown, value}; blank decodes to F without flagging an error
   function automatic logic [4:0] decode_seg(input logic [6:0] seg);
      logic [4:0] res;
      case (seg)
         7'b1000000: res = 5'h00;
         7'b1111001: res = 5'h01;
         7'b0100100: res = 5'h02;
         7'b0110000: res = 5'h03;
         7'b0011001: res = 5'h04;
         7'b0010010: res = 5'h05;
         7'b0000010: res = 5'h06;
         7'b1111000: res = 5'h07;
         7'b0000000: res = 5'h08;
         7'b0011000: res = 5'h09;
         7'b1111111: res = 5'h0F;
         default:    res = 5'h1E;
      endcase
      return res;
   endfunction

   // True when exactly one digit enable is asserted
   function automatic logic is_onehot(input logic [DIGITS-1:0] v);
      return (v != {DIGITS{1'b0}}) &&
             ((v & (v - DIGITS'(1'b1))) == {DIGITS{1'b0}});
   endfunction

   // Index of the asserted bit of a one-hot vector
   function automatic logic [2:0] onehot_index(input logic [DIGITS-1:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[i]) begin
            idx = 3'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   logic [6:0]          seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d;
   logic [DIGITS-1:0]   an_s1_q, an_s1_d, an_s2_q, an_s2_d;
   logic [SMP_W-1:0]    prev_q, prev_d;
   logic [1:0]          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [4*DIGITS-1:0] bcd_q, bcd_d;
   logic [DIGITS-1:0]   valid_q, valid_d;
   logic [DIGITS-1:0]   seen_q, seen_d;
   logic                frame_q, frame_d;
   logic                err_q, err_d;
   logic [2:0]          err_digit_q, err_digit_d;

   logic [SMP_W-1:0]    samp_s;
   logic                an_onehot_s;
   logic                same_s;
   logic                capture_s;
   logic [4:0]          dec_s;
   logic [2:0]          cap_idx_s;
   logic [DIGITS-1:0]   seen_next_s;

   assign samp_s      = {seg_s2_q, an_s2_q};
   assign an_onehot_s = is_onehot(an_s2_q);
   assign same_s      = (samp_s == prev_q);
   assign dec_s       = decode_seg(seg_s2_q);
   assign cap_idx_s   = onehot_index(an_s2_q);

   // Two-stage synchronisers; enables are normalised to active-high on entry
   always_comb begin
      seg_s1_d = seg_in;
      seg_s2_d = seg_s1_q;
      an_s1_d  = (AN_ACT_LOW != 0) ? ~an_in : an_in;
      an_s2_d  = an_s1_q;
      prev_d   = samp_s;
   end

   // Settle FSM: counts consecutive identical samples of a single enabled digit
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      capture_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (an_onehot_s) begin
               state_d = ST_SETTLE;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = CNT_ZERO;
            end
         end
         ST_SETTLE: begin
            if (!an_onehot_s) begin
               state_d = ST_IDLE;
               cnt_d   = CNT_ZERO;
            end else if (!same_s) begin
               cnt_d   = CNT_ONE;
            end else if (cnt_q == CNT_LAST) begin
               capture_s = 1'b1;
               state_d   = ST_HOLD;
               cnt_d     = CNT_ZERO;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         ST_HOLD: begin
            if (!an_onehot_s) begin
               state_d = ST_IDLE;
               cnt_d   = CNT_ZERO;
            end else if (!same_s) begin
               state_d = ST_SETTLE;
               cnt_d   = CNT_ONE;
            end else begin
               state_d = ST_HOLD;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
         end
      endcase
   end

   // Capture path: digit register update, frame tracking and error reporting
   always_comb begin
      bcd_d       = bcd_q;
      valid_d     = valid_q;
      seen_d      = seen_q;
      frame_d     = 1'b0;
      err_d       = 1'b0;
      err_digit_d = err_digit_q;
      seen_next_s = seen_q | an_s2_q;
      if (capture_s) begin
         for (int k = 0; k < DIGITS; k++) begin
            if (an_s2_q[k]) begin
               bcd_d[4*k +: 4] = dec_s[3:0];
            end else begin
               bcd_d[4*k +: 4] = bcd_q[4*k +: 4];
            end
         end
         valid_d = valid_q | an_s2_q;
         // The digit that completes a frame is not carried into the next one
         if (&seen_next_s) begin
            frame_d = 1'b1;
            seen_d  = {DIGITS{1'b0}};
         end else begin
            seen_d  = seen_next_s;
         end
         if (dec_s[4]) begin
            err_d       = 1'b1;
            err_digit_d = cap_idx_s;
         end else begin
            err_digit_d = err_digit_q;
         end
      end else begin
         seen_d = seen_q;
      end
   end

   // State registers; reset discards any capture due on the same edge
   always_ff @(posedge clk) begin
      if (rst) begin
         seg_s1_q    <= 7'd0;
         seg_s2_q    <= 7'd0;
         an_s1_q     <= {DIGITS{1'b0}};
         an_s2_q     <= {DIGITS{1'b0}};
         prev_q      <= {SMP_W{1'b0}};
         state_q     <= ST_IDLE;
         cnt_q       <= CNT_ZERO;
         bcd_q       <= {(4*DIGITS){1'b0}};
         valid_q     <= {DIGITS{1'b0}};
         seen_q      <= {DIGITS{1'b0}};
         frame_q     <= 1'b0;
         err_q       <= 1'b0;
         err_digit_q <= 3'd0;
      end else begin
         seg_s1_q    <= seg_s1_d;
         seg_s2_q    <= seg_s2_d;
         an_s1_q     <= an_s1_d;
         an_s2_q     <= an_s2_d;
         prev_q      <= prev_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bcd_q       <= bcd_d;
         valid_q     <= valid_d;
         seen_q      <= seen_d;
         frame_q     <= frame_d;
         err_q       <= err_d;
         err_digit_q <= err_digit_d;
      end
   end

   assign bcd_out     = bcd_q;
   assign digit_valid = valid_q;
   assign frame_valid = frame_q;
   assign err         = err_q;
   assign err_digit   = err_digit_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Bench for seg7_scan_reader: directed display-scan stimulus, a run-length
// reference model checked on every cycle, plus hand-computed spot checks.

module tb_seg7_scan_reader;

   localparam int DIGITS     = 4;
   localparam int STABLE_CYC = 4;
   localparam int AN_ACT_LOW = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  seg_in;
   logic [3:0]  an_in;
   logic [15:0] bcd_out;
   logic [3:0]  digit_valid;
   logic        frame_valid;
   logic        err;
   logic [2:0]  err_digit;

   seg7_scan_reader #(
      .DIGITS(DIGITS), .STABLE_CYC(STABLE_CYC), .AN_ACT_LOW(AN_ACT_LOW)
   ) dut (
      .clk(clk), .rst(rst), .seg_in(seg_in), .an_in(an_in),
      .bcd_out(bcd_out), .digit_valid(digit_valid), .frame_valid(frame_valid),
      .err(err), .err_digit(err_digit)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int frame_cnt = 0;
   int err_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Segment patterns for decimal digits 0..9
   logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0011000};

   // Reference model: a digit is captured on the STABLE_CYC-th sample of any
   // run of identical samples with exactly one digit enabled; samples reach the
   // decision point two clocks after they are presented.
   logic [10:0] m_pipe [2];
   logic [10:0] m_last;
   int          m_run;
   logic [15:0] m_bcd;
   logic [3:0]  m_valid, m_seen;
   logic        m_frame, m_err;
   logic [2:0]  m_errd;
   bit          live = 1'b0;

   task automatic model_step(input logic r, input logic [6:0] sg, input logic [3:0] an);
      logic [10:0] s;
      logic [3:0]  a;
      logic [3:0]  val;
      bit          known;
      int          idx;
      if (r) begin
         m_pipe[0] = '0; m_pipe[1] = '0; m_last = '0; m_run = 0;
         m_bcd = '0; m_valid = '0; m_seen = '0;
         m_frame = 1'b0; m_err = 1'b0; m_errd = '0;
         live = 1'b1;
      end else begin
         s = m_pipe[1];
         m_pipe[1] = m_pipe[0];
         m_pipe[0] = {sg, (AN_ACT_LOW != 0) ? ~an : an};
         a = s[3:0];
         if ($onehot(a) && m_run > 0 && s == m_last) m_run++;
         else if ($onehot(a)) m_run = 1;
         else m_run = 0;
         m_last = s;
         m_frame = 1'b0;
         m_err = 1'b0;
         if (m_run == STABLE_CYC) begin
            val = 4'hE; known = 1'b0; idx = 0;
            if (s[10:4] == 7'b1111111) begin val = 4'hF; known = 1'b1; end
            for (int i = 0; i < 10; i++)
               if (seg_tab[i] == s[10:4]) begin val = 4'(i); known = 1'b1; end
            for (int i = 0; i < DIGITS; i++)
               if (a[i]) begin m_bcd[4*i +: 4] = val; idx = i; end
            m_valid = m_valid | a;
            m_seen = m_seen | a;
            if (m_seen == 4'hF) begin m_frame = 1'b1; m_seen = '0; end
            if (!known) begin m_err = 1'b1; m_errd = 3'(idx); end
         end
      end
   endtask

   logic       l_rst;
   logic [6:0] l_seg;
   logic [3:0] l_an;
   bit         l_ok = 1'b0;

   // Inputs are latched mid-cycle and applied to the model at the next edge;
   // outputs registered at that edge are compared one half-cycle later.
   always @(negedge clk) begin
      if (l_ok) model_step(l_rst, l_seg, l_an);
      if (live) begin
         check("bcd_out", 32'(bcd_out), 32'(m_bcd));
         check("digit_valid", 32'(digit_valid), 32'(m_valid));
         check("frame_valid", 32'(frame_valid), 32'(m_frame));
         check("err", 32'(err), 32'(m_err));
         check("err_digit", 32'(err_digit), 32'(m_errd));
         if (frame_valid === 1'b1) frame_cnt++;
         if (err === 1'b1) err_cnt++;
      end
      l_rst = rst; l_seg = seg_in; l_an = an_in; l_ok = 1'b1;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic show(input logic [3:0] an, input logic [6:0] sg, input int n);
      an_in = an;
      seg_in = sg;
      tick(n);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   int f0, e0;

   initial begin
      // Reset with random inputs
      rst = 1'b1;
      seg_in = 7'($urandom);
      an_in = 4'($urandom);
      repeat (3) begin
         @(posedge clk);
         #1;
         seg_in = 7'($urandom);
         an_in = 4'($urandom);
      end
      check("rst_bcd", 32'(bcd_out), 32'h0);
      check("rst_valid", 32'(digit_valid), 32'h0);
      check("rst_frame", 32'(frame_valid), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      check("rst_errd", 32'(err_digit), 32'h0);

      // Single digit: '2' on digit0, captured exactly 6 edges after apply
      rst = 1'b0;
      show(4'b1110, 7'b0100100, 5);
      check("t2_early_bcd", 32'(bcd_out[3:0]), 32'h0);
      check("t2_early_valid", 32'(digit_valid), 32'h0);
      tick(1);
      check("t2_bcd", 32'(bcd_out[3:0]), 32'h2);
      check("t2_valid", 32'(digit_valid), 32'h1);
      check("t2_err", 32'(err), 32'h0);
      tick(4);

      // Full scan 1,9,0,7
      f0 = frame_cnt;
      show(4'b1110, 7'b1111001, 8);
      show(4'b1101, 7'b0011000, 8);
      show(4'b1011, 7'b1000000, 8);
      show(4'b0111, 7'b1111000, 8);
      check("t3_bcd", 32'(bcd_out), 32'h7091);
      check("t3_frames", 32'(frame_cnt - f0), 32'd1);

      // Glitch on digit1
      e0 = err_cnt;
      show(4'b1101, 7'b0000000, 3);
      show(4'b1101, 7'b0000001, 1);
      show(4'b1101, 7'b0000000, 5);
      check("t4_pre_bcd", 32'(bcd_out[7:4]), 32'h9);
      tick(1);
      check("t4_bcd", 32'(bcd_out[7:4]), 32'h8);
      tick(2);
      check("t4_errs", 32'(err_cnt - e0), 32'd0);

      // Invalid pattern then blank on digit2, then non-one-hot enables
      show(4'b1011, 7'b0101010, 6);
      check("t5_err", 32'(err), 32'h1);
      check("t5_errd", 32'(err_digit), 32'h2);
      check("t5_bcd", 32'(bcd_out[11:8]), 32'hE);
      tick(1);
      check("t5_err_clr", 32'(err), 32'h0);
      tick(1);
      e0 = err_cnt;
      show(4'b1011, 7'b1111111, 8);
      check("t5_blank", 32'(bcd_out[11:8]), 32'hF);
      check("t5_blank_err", 32'(err_cnt - e0), 32'd0);
      show(4'b0000, 7'b0000000, 8);
      show(4'b1100, 7'b0000000, 8);
      check("t5_nocap_bcd", 32'(bcd_out), 32'h7F81);
      check("t5_nocap_valid", 32'(digit_valid), 32'hF);

      // Reset on the edge a capture is due
      show(4'b1110, 7'b0110000, 5);
      rst = 1'b1;
      tick(1);
      check("t6_bcd", 32'(bcd_out), 32'h0);
      check("t6_valid", 32'(digit_valid), 32'h0);
      rst = 1'b0;
      tick(5);
      check("t6_pre_bcd", 32'(bcd_out[3:0]), 32'h0);
      tick(1);
      check("t6_bcd_after", 32'(bcd_out[3:0]), 32'h3);
      check("t6_valid_after", 32'(digit_valid), 32'h1);
      tick(2);

      // Remaining digits complete a frame after reset
      f0 = frame_cnt;
      show(4'b1101, 7'b0011001, 8);
      show(4'b1011, 7'b0010010, 8);
      show(4'b0111, 7'b0000010, 8);
      check("t7_bcd", 32'(bcd_out), 32'h6543);
      check("t7_frames", 32'(frame_cnt - f0), 32'd1);
      tick(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
